// File: rtl/sdft_comb.sv
// Sliding-DFT comb stage: y[n] = x[n] - x[n-N] over an N-deep ring buffer.
// Two-stage pipeline (RAM read + delayed sample, then subtract), one sample per cycle.
module sdft_comb #(
    parameter  int DW = 16,
    parameter  int N  = 256,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 flush_i,
    input  logic signed [DW-1:0] sample_i,
    input  logic                 sample_valid_i,
    output logic signed [DW:0]   comb_o,
    output logic                 comb_valid_o,
    output logic                 primed_o
);

    localparam int STAGES = 2;

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wr_ptr;
    logic [STAGES:1]      vld_pipe;
    logic signed [DW-1:0] mem [N];
    logic signed [DW-1:0] rd_q;
    logic signed [DW-1:0] smp_q;
    logic                 old_zero_q;
    logic                 old_zero;
    logic                 accept;
    logic                 last_fill;
    logic signed [DW:0]   diff;

    // A flush discards a coincident sample.
    assign accept = sample_valid_i && !flush_i;

    // While filling, wr_ptr equals the number of samples taken since the window
    // restarted, so it doubles as the fill count: the N-th sample lands at N-1.
    assign last_fill = (wr_ptr == AW'(N - 1));

    // State register and write pointer; flush restarts the window.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= FILL;
            wr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i)
                wr_ptr <= '0;
            else if (accept)
                wr_ptr <= last_fill ? '0 : wr_ptr + 1'b1;
        end
    end

    // Next state: FILL until the N-th accepted sample, flush returns to FILL.
    always_comb begin
        state_d = state_q;
        if (flush_i)
            state_d = FILL;
        else if (accept && (state_q == FILL) && last_fill)
            state_d = RUN;
    end

    // State decode: RAM contents are meaningless until a full window is written.
    always_comb begin
        old_zero = (state_q == FILL);
        primed_o = (state_q == RUN);
    end

    // Ring buffer, read-before-write on the shared address; contents never reset.
    always_ff @(posedge clk_i) begin
        if (accept && !srst_i) begin
            rd_q         <= mem[wr_ptr];
            mem[wr_ptr]  <= sample_i;
        end
    end

    // One extra bit of headroom makes the difference exact over the full input range.
    assign diff = {smp_q[DW-1], smp_q} - (old_zero_q ? '0 : {rd_q[DW-1], rd_q});

    // Stage-1 sample/flag, stage-2 subtract, valid shift; flush kills in-flight samples.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            vld_pipe   <= '0;
            smp_q      <= '0;
            old_zero_q <= 1'b1;
            comb_o     <= '0;
        end else begin
            vld_pipe[1] <= accept;
            vld_pipe[2] <= vld_pipe[1] && !flush_i;
            if (accept) begin
                smp_q      <= sample_i;
                old_zero_q <= old_zero;
            end
            if (vld_pipe[1] && !flush_i)
                comb_o <= diff;
        end
    end

    assign comb_valid_o = vld_pipe[STAGES];

endmodule
